// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with post-reset clear sweep,
// 1/2-cycle read pipeline, read-valid strobe and out-of-range detection.
module ram_sp_param #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 6,
  parameter int                DEPTH     = 64,
  parameter int                READ_LAT  = 1,
  parameter int                CLEAR_EN  = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              enable,
  input  logic              r_w,
  input  logic [ADDR_W-1:0] add,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              clr_we;

  logic              in_range, acc, acc_rd, acc_wr;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, rd_dat;

  logic              p_vld;
  logic [DATA_W-1:0] p_dat;

  logic [DATA_W-1:0] dout_q;
  logic              rvld_q, aerr_q;

  // Clear sweep: one word per ce-cycle, last word moves us to READY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (ce) begin
          clr_we = 1'b1;
          ptr_d  = ptr_q + ADDR_W'(1);
          if (ptr_q == LAST) state_d = ST_READY;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (CLEAR_EN != 0) ? ST_CLEAR : ST_READY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign in_range = ({1'b0, add} < DEPTH_X);
  assign acc      = rst_n & ce & enable & ~busy;
  assign acc_rd   = acc & ~r_w;
  assign acc_wr   = acc & r_w & in_range;

  // Sweep and access writes never coincide: accesses are blocked while busy.
  assign we      = rst_n & (clr_we | acc_wr);
  assign wr_addr = clr_we ? ptr_q : add;
  assign wr_data = clr_we ? CLEAR_VAL : data_in;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_dat = in_range ? mem[add] : '0;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              s_vld_q;
      logic [DATA_W-1:0] s_dat_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s_vld_q <= 1'b0;
          s_dat_q <= '0;
        end else if (ce) begin
          s_vld_q <= acc_rd;
          if (acc_rd) s_dat_q <= rd_dat;
        end
      end
      assign p_vld = s_vld_q;
      assign p_dat = s_dat_q;
    end else begin : g_lat1
      assign p_vld = acc_rd;
      assign p_dat = rd_dat;
    end
  endgenerate

  // Output stage: data holds between reads, strobes last one ce-cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvld_q <= 1'b0;
      aerr_q <= 1'b0;
      dout_q <= '0;
    end else if (ce) begin
      rvld_q <= p_vld;
      aerr_q <= acc & ~in_range;
      if (p_vld) dout_q <= p_dat;
    end
  end

  assign data_out = dout_q;
  assign rd_valid = rvld_q;
  assign addr_err = aerr_q;

endmodule

// File: tb/tb_ram_sp_param.sv
// Bench for ram_sp_param: three parameterisations sharing bus inputs with
// per-instance enables; scoreboard on the LAT=1 instance, vector table on DEPTH=40.
module tb_ram_sp_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, ce = 1'b1, r_w = 1'b0;
  logic [5:0]  add = '0;
  logic [15:0] din = '0;
  logic        en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;

  logic [15:0] dout0, dout1, dout2;
  logic        vld0, vld1, vld2, busy0, busy1, busy2, err0, err1, err2;

  int n_vec = 0, n_bad = 0, cyc = 0;

  typedef struct {logic [15:0] dat; int cyc;} sb_t;
  sb_t sbq[$];
  logic [15:0] model0 [64];

  typedef struct {
    logic en; logic rw; logic [5:0] a; logic [15:0] d;
    logic vld; logic err; logic [15:0] dout;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  ram_sp_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .READ_LAT(1), .CLEAR_EN(1),
                 .CLEAR_VAL(16'hA5A5)) u0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .enable(en0), .r_w(r_w), .add(add),
    .data_in(din), .data_out(dout0), .rd_valid(vld0), .busy(busy0), .addr_err(err0));

  ram_sp_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .READ_LAT(2), .CLEAR_EN(0),
                 .CLEAR_VAL(16'h0000)) u1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .enable(en1), .r_w(r_w), .add(add),
    .data_in(din), .data_out(dout1), .rd_valid(vld1), .busy(busy1), .addr_err(err1));

  ram_sp_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(40), .READ_LAT(1), .CLEAR_EN(1),
                 .CLEAR_VAL(16'h0000)) u2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .enable(en2), .r_w(r_w), .add(add),
    .data_in(din), .data_out(dout2), .rd_valid(vld2), .busy(busy2), .addr_err(err2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // One clock; outputs sampled on the falling edge, u0 reads retired here.
  task automatic step();
    sb_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("u0 addr_err", 32'(err0), 32'd0);
    if (vld0) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL u0 rd_valid: got unexpected pulse, required none");
      end else begin
        e = sbq.pop_front();
        chk("u0 rd data", 32'(dout0), 32'(e.dat));
        chk("u0 rd latency", cyc, e.cyc + 1);
      end
    end
  endtask

  task automatic rd0(input int a);
    en0 = 1'b1; r_w = 1'b0; add = 6'(a);
    sbq.push_back('{model0[a], cyc});
    step();
  endtask

  task automatic sweep_fill();
    for (int i = 0; i < 64; i++) model0[i] = 16'hA5A5;
  endtask

  initial begin
    int k0, k2;

    // ---- reset state ----
    step(); step();
    chk("u0 busy in reset", 32'(busy0), 32'd1);
    chk("u0 data_out reset", 32'(dout0), 32'd0);
    chk("u0 rd_valid reset", 32'(vld0), 32'd0);
    chk("u1 busy no-clear", 32'(busy1), 32'd0);
    chk("u2 busy in reset", 32'(busy2), 32'd1);
    chk("u2 addr_err reset", 32'(err2), 32'd0);

    // ---- sweep length, plus a write attempted while busy ----
    rst_n = 1'b1; k0 = 0; k2 = 0;
    for (int k = 1; k <= 200; k++) begin
      if (k == 40) begin en0 = 1'b1; r_w = 1'b1; add = 6'd5; din = 16'h1234; end
      else en0 = 1'b0;
      step();
      if (!busy0 && k0 == 0) k0 = k;
      if (!busy2 && k2 == 0) k2 = k;
      if (k0 != 0 && k2 != 0) break;
    end
    en0 = 1'b0;
    chk("u0 sweep length", k0, 64);
    chk("u2 sweep length", k2, 40);
    sweep_fill();

    // ---- sweep contents; @5 must not hold the busy-time write ----
    rd0(0); rd0(31); rd0(63); rd0(5);
    en0 = 1'b0; step();

    // ---- full-depth write then back-to-back reads ----
    for (int a = 0; a < 64; a++) begin
      en0 = 1'b1; r_w = 1'b1; add = 6'(a); din = 16'(a * 3);
      model0[a] = 16'(a * 3);
      step();
    end
    for (int a = 0; a < 64; a++) rd0(a);
    en0 = 1'b0; step();
    chk("u0 scoreboard drained", sbq.size(), 0);

    // ---- READ_LAT=2 read-after-write ----
    en1 = 1'b1; r_w = 1'b1; add = 6'd5; din = 16'h1234; step();
    r_w = 1'b0; step();
    en1 = 1'b0;
    chk("u1 rd_valid at lat 1", 32'(vld1), 32'd0);
    step();
    chk("u1 rd_valid at lat 2", 32'(vld1), 32'd1);
    chk("u1 data at lat 2", 32'(dout1), 32'h1234);
    step();
    chk("u1 rd_valid after pulse", 32'(vld1), 32'd0);
    chk("u1 data held", 32'(dout1), 32'h1234);

    // ---- ce stall with a read in flight ----
    en1 = 1'b1; r_w = 1'b1; add = 6'd7; din = 16'h00FF; step();
    r_w = 1'b0; step();
    en1 = 1'b0; ce = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("u1 rd_valid during stall", 32'(vld1), 32'd0);
      chk("u1 data frozen", 32'(dout1), 32'h1234);
    end
    ce = 1'b1; step();
    chk("u1 rd_valid after stall", 32'(vld1), 32'd1);
    chk("u1 data after stall", 32'(dout1), 32'h00FF);
    step();
    chk("u1 single pulse", 32'(vld1), 32'd0);

    // ---- DEPTH=40 vector table ----
    tbl[0]  = '{1'b1, 1'b1, 6'd39, 16'h1111, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 6'd45, 16'hBEEF, 1'b0, 1'b1, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 6'd45, 16'h0000, 1'b1, 1'b1, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 6'd39, 16'h0000, 1'b1, 1'b0, 16'h1111};
    tbl[4]  = '{1'b1, 1'b0, 6'd5,  16'h0000, 1'b1, 1'b0, 16'h0000};
    tbl[5]  = '{1'b1, 1'b1, 6'd63, 16'h2222, 1'b0, 1'b1, 16'h0000};
    tbl[6]  = '{1'b1, 1'b0, 6'd63, 16'h0000, 1'b1, 1'b1, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 6'd39, 16'h0000, 1'b1, 1'b0, 16'h1111};
    tbl[8]  = '{1'b1, 1'b1, 6'd0,  16'h3333, 1'b0, 1'b0, 16'h1111};
    tbl[9]  = '{1'b1, 1'b0, 6'd0,  16'h0000, 1'b1, 1'b0, 16'h3333};
    tbl[10] = '{1'b1, 1'b0, 6'd40, 16'h0000, 1'b1, 1'b1, 16'h0000};
    tbl[11] = '{1'b1, 1'b0, 6'd13, 16'h0000, 1'b1, 1'b0, 16'h0000};
    tbl[12] = '{1'b0, 1'b0, 6'd0,  16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[13] = '{1'b1, 1'b0, 6'd0,  16'h0000, 1'b1, 1'b0, 16'h3333};
    tbl[14] = '{1'b0, 1'b1, 6'd45, 16'h0000, 1'b0, 1'b0, 16'h3333};
    for (int i = 0; i < 15; i++) begin
      en2 = tbl[i].en; r_w = tbl[i].rw; add = tbl[i].a; din = tbl[i].d;
      step();
      chk($sformatf("u2 vec%0d rd_valid", i), 32'(vld2), 32'(tbl[i].vld));
      chk($sformatf("u2 vec%0d addr_err", i), 32'(err2), 32'(tbl[i].err));
      chk($sformatf("u2 vec%0d data_out", i), 32'(dout2), 32'(tbl[i].dout));
    end
    en2 = 1'b0;

    // ---- reset with a READ_LAT=2 read in flight ----
    en1 = 1'b1; r_w = 1'b0; add = 6'd5; step();
    en1 = 1'b0; rst_n = 1'b0; step();
    chk("u1 rd_valid in reset", 32'(vld1), 32'd0);
    chk("u1 data_out in reset", 32'(dout1), 32'd0);
    rst_n = 1'b1; step();
    chk("u1 flushed read", 32'(vld1), 32'd0);
    en1 = 1'b1; step();
    en1 = 1'b0; step();
    chk("u1 mem kept over reset", 32'(dout1), 32'h1234);

    // ---- reset mid-sweep at pointer 20 ----
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    for (int s = 0; s < 20; s++) step();
    chk("u0 busy mid-sweep", 32'(busy0), 32'd1);
    rst_n = 1'b0; step();
    rst_n = 1'b1; k0 = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (!busy0) begin k0 = k; break; end
    end
    chk("u0 restarted sweep length", k0, 64);
    sweep_fill();
    rd0(20); rd0(63); rd0(32);
    en0 = 1'b0; step();
    chk("u0 final scoreboard drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_sp_param.md
Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM for the CPU data/instruction store. It is the next generation of the fixed 64x16 RAM.
- Data width, depth and read latency are configurable.
- Adds a post-reset clear engine, read-valid signalling, a selectable 1- or 2-cycle read pipeline, and out-of-range address detection.
- Sits between the CPU control unit and the memory bus. Keeps the existing add/data_in/r_w/enable/ce access semantics.

Parameters:
- DATA_W, 16, word width in bits (>=1).
- ADDR_W, 6, address width in bits.
- DEPTH, 64, number of words (1..2^ADDR_W). All DEPTH words are physically implemented.
- READ_LAT, 1, read latency in accepted-clock cycles. Legal values: 1 or 2.
- CLEAR_EN, 1, 1 = sweep memory to CLEAR_VAL after reset; 0 = no sweep.
- CLEAR_VAL, 0, DATA_W-bit value written during the clear sweep.

Ports:
- clk, input, 1, clock. All logic on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- ce, input, 1, clock enable. When 0, all internal state and outputs freeze.
- enable, input, 1, access request.
- r_w, input, 1, 0 = read, 1 = write.
- add, input, ADDR_W, word address.
- data_in, input, DATA_W, write data.
- data_out, output, DATA_W, read data. Holds its last value between reads.
- rd_valid, output, 1, one-cycle pulse: data_out updated with a read result this cycle.
- busy, output, 1, clear sweep in progress; accesses are ignored.
- addr_err, output, 1, one-cycle pulse: an accepted access had add >= DEPTH.

Behaviour:
- Reset (rst_n=0 at a clock edge, overrides ce):
  - data_out=0, rd_valid=0, addr_err=0, read pipeline flushed.
  - Clear pointer=0. busy=1 if CLEAR_EN=1, else busy=0.
  - Memory contents are not modified by reset itself.
- FSM states: CLEAR, READY.
  - Reset enters CLEAR when CLEAR_EN=1, otherwise READY.
  - CLEAR: each cycle with ce=1, write CLEAR_VAL to mem[ptr] and increment ptr.
  - When ptr=DEPTH-1 is written, go to READY. busy drops on the next edge.
  - A sweep therefore takes exactly DEPTH ce-cycles after reset release.
  - Reset mid-sweep restarts the sweep at ptr=0.
  - READY is terminal until the next reset.
- Accepted access: ce=1 & enable=1 & busy=0 & rst_n=1.
  - enable asserted while busy or ce=0 is dropped: no write, no rd_valid, no addr_err.
- Write (r_w=1, add<DEPTH): mem[add] <= data_in at that edge. No response pulses.
- Read (r_w=0, add<DEPTH):
  - data_out <= mem[add] and rd_valid=1 exactly READ_LAT ce-cycles after acceptance.
  - READ_LAT=1 matches the legacy timing: data appears on the edge after the request.
  - READ_LAT=2 adds an output register stage.
- Pipelining: one access may be accepted every ce-cycle. Back-to-back reads yield back-to-back rd_valid pulses in request order.
- Read after write: a read accepted in the cycle after a write to the same address returns the new data, for both latencies.
- Out-of-range access (add >= DEPTH, possible only when DEPTH < 2^ADDR_W):
  - addr_err=1 on the next ce-cycle.
  - A write is discarded and memory is untouched.
  - A read still produces rd_valid at the normal latency, with data_out=0.
- ce=0 freezes the FSM, clear pointer, read pipeline and outputs. Pulses pending in the pipeline resume when ce returns to 1. A pulse is never dropped or duplicated.
- rd_valid and addr_err are single-cycle pulses. addr_err is 0 in every cycle not caused by an out-of-range access.

Test Plan:
- Reset sweep, DEPTH=64, CLEAR_EN=1, CLEAR_VAL=16'hA5A5:
  - Release rst_n -> busy=1 for exactly 64 cycles, then 0.
  - Reading addresses 0, 31, 63 returns 16'hA5A5.
  - Writes issued during busy leave memory unchanged.
- Full-depth write/read, READ_LAT=1:
  - Write data=add*3 to all 64 addresses, then read 0..63 back-to-back.
  - Result: 64 consecutive rd_valid pulses, each one cycle after its request, with correct data. Address 32 and above must not alias the lower half.
- READ_LAT=2:
  - Write 16'h1234 @5 then read @5 on the next cycle -> data_out=16'h1234 with rd_valid exactly 2 cycles after the read request.
  - data_out holds that value afterwards.
- ce stall:
  - Issue a read of @7 (value 16'h00FF), drop ce for 3 cycles, restore ce.
  - Result: rd_valid fires once, READ_LAT ce-cycles after acceptance excluding stalled cycles, with data_out=16'h00FF. Outputs are frozen while ce=0.
- Out of range, DEPTH=40, ADDR_W=6:
  - Write 16'hBEEF @45 -> addr_err pulse, no memory change.
  - Read @45 -> addr_err pulse plus rd_valid with data_out=0.
  - Read @39 -> normal data, no addr_err.
- Reset mid-operation:
  - Assert rst_n=0 for 1 cycle during sweep pointer 20 -> sweep restarts at 0, busy lasts a full DEPTH cycles.
  - Reset with a read in flight -> no rd_valid after reset, data_out=0.
